depthwise_win_sched: RTL and testbench
======================================

// Module: depthwise_win_sched
// PURPOSE
//  Sequences one frame through the 5x5 depthwise stage.
//  - Accepts the raster pixel stream (valid/ready) and drives the line-buffer shift enable.
//  - Decides which pixel completes a legal KxK window (size + stride) and issues one window-valid
//    strobe per output position to the depthwise MAC, with the output row/col tag.
//  - Handles downstream back-pressure, then signals frame completion.
// PARAMETERS
//  IMG_W   12  input feature-map width (pixels)
//  IMG_H   12  input feature-map height (rows)
//  K       5   kernel size; first legal window completes at (K-1,K-1)
//  STRIDE  1   window stride in both axes (1 or 2)
//  CW      5   width of row/col counters and output tags; must hold max(IMG_W,IMG_H)-1
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   frame start pulse; sampled only in IDLE
//  pix_valid    in   1   upstream pixel available
//  pix_ready    out  1   scheduler accepts pixel this cycle
//  shift_en     out  1   line-buffer/window shift = pix_valid & pix_ready (combinational)
//  win_valid    out  1   window ready for depthwise MAC (drives its valid_out_buf)
//  dn_ready     in   1   depthwise/downstream consumes window this cycle
//  out_row      out  CW  output row index of presented window (0-based)
//  out_col      out  CW  output col index of presented window (0-based)
//  busy         out  1   high in RUN and DRAIN
//  frame_done   out  1   one-cycle pulse after last window handshake
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; win_valid=0; out_row=out_col=0; frame_done=0;
//    row/col counters and stride phases=0. pix_ready=0 and busy=0 follow from IDLE.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    IDLE  -start->  RUN; counters cleared.
//    RUN   -accept of pixel (IMG_H-1,IMG_W-1)->  DRAIN.
//    DRAIN -(!win_valid | dn_ready)->  DONE.
//    DONE  -> IDLE after one cycle; frame_done=1 for exactly that cycle.
//  - start outside IDLE is ignored.
//  - pix_ready = (state==RUN) & !(win_valid & !dn_ready). Never accept a pixel while a window is stalled.
//  - Accept moves col 0..IMG_W-1; wrap to 0 increments row. No wrap beyond last row.
//  - Window qualify on accept of (r,c):
//      r>=K-1, c>=K-1, row phase==0 and col phase==0.
//    Phases count modulo STRIDE starting at r=K-1 / c=K-1 (no divider).
//  - On qualify, the next cycle gives:
//      win_valid=1;
//      out_row=(r-(K-1))/STRIDE and out_col=(c-(K-1))/STRIDE, from tag counters.
//    Latency accept->win_valid = 1 clk.
//  - win_valid and tags hold until dn_ready=1, then clear unless a new window qualifies in the same cycle.
//    Back-to-back windows allowed: with STRIDE=1 and dn_ready=1, one window per clk.
//  - Simultaneous dn_ready consumption and new qualify: win_valid stays 1, tags update.
//  - Windows per frame:
//      ((IMG_H-K)/STRIDE+1)*((IMG_W-K)/STRIDE+1);
//      12x12,K5 gives 64 (S=1) or 16 (S=2).
//  - Reset mid-frame discards the partial frame; no frame_done is issued.
// CONFIGURATION
//  - DWC_STALL_CNT_EN defined:
//    - Adds output port stall_cnt[15:0]: counts clocks with win_valid & !dn_ready.
//    - Saturates at 16'hFFFF; cleared on accepted start; reset 0; holds after frame.
//  - DWC_STALL_CNT_EN undefined: port and logic absent; all other behaviour identical.
// TESTING
//  1. Defaults, start, pix_valid=1, dn_ready=1 for 144 pixels -> 64 win_valid pulses:
//     - first on clk after pixel (4,4), tag (0,0); last tag (7,7);
//     - frame_done exactly 2 clks after last accept.
//  2. STRIDE=2, same stream -> 16 windows, tags (0,0)..(3,3); no window for c=11 or r=11.
//  3. Drop dn_ready for 3 clks on window (2,5) ->
//     - pix_ready=0 those 3 clks, win_valid and tag held, no pixel lost;
//     - 64 windows total; stall_cnt=3 when DWC_STALL_CNT_EN is defined.
//  4. Random pix_valid gaps, dn_ready=1 -> window sequence and tags identical to scenario 1;
//     shift_en count = 144.
//  5. start pulsed during RUN -> ignored, counters unaffected; start after frame_done -> new frame from (0,0).
//  6. rst_n low after pixel 60 (async, mid-clock) ->
//     - outputs zero immediately, no frame_done;
//     - a following full frame yields 64 correct windows.

Source files
------------

// File: rtl/depthwise_win_sched.sv
// Frame scheduler for the 5x5 depthwise stage: accepts the raster pixel stream, flags legal KxK windows
// (size + stride) with their output tags, and absorbs downstream back-pressure. Option: DWC_STALL_CNT_EN.
`default_nettype none

module depthwise_win_sched #(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int CW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          shift_en,
  output logic          win_valid,
  input  logic          dn_ready,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          frame_done
`ifdef DWC_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] KM1      = CW'(K - 1);
  localparam logic [CW-1:0] PH_MAX   = CW'(STRIDE - 1);

  state_t        state;
  state_t        state_nxt;

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] row_ph;
  logic [CW-1:0] col_ph;
  logic [CW-1:0] tag_row;
  logic [CW-1:0] tag_col;

  logic          accept;
  logic          start_acc;
  logic          last_pix;
  logic          row_in;
  logic          col_in;
  logic          qualify;
  logic          drain_exit;

  // A stalled window must not be overwritten, so input is blocked while it waits.
  assign pix_ready  = (state == RUN) && !(win_valid && !dn_ready);
  assign shift_en   = pix_valid && pix_ready;
  assign accept     = shift_en;
  assign start_acc  = (state == IDLE) && start;
  assign last_pix   = (row == LAST_ROW) && (col == LAST_COL);
  assign row_in     = (row >= KM1);
  assign col_in     = (col >= KM1);
  assign qualify    = accept && row_in && col_in && (row_ph == '0) && (col_ph == '0);
  assign drain_exit = (state == DRAIN) && (!win_valid || dn_ready);
  assign busy       = (state == RUN) || (state == DRAIN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (!win_valid || dn_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position plus stride phases; tag counters track the output index of the next legal window,
  // so no division is needed to produce out_row/out_col.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= '0;
      col     <= '0;
      row_ph  <= '0;
      col_ph  <= '0;
      tag_row <= '0;
      tag_col <= '0;
    end else if (start_acc) begin
      row     <= '0;
      col     <= '0;
      row_ph  <= '0;
      col_ph  <= '0;
      tag_row <= '0;
      tag_col <= '0;
    end else if (accept) begin
      if (col == LAST_COL) begin
        col     <= '0;
        col_ph  <= '0;
        tag_col <= '0;
        if (row != LAST_ROW) begin
          row <= row + CW'(1);
        end
        if (row_in) begin
          row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + CW'(1);
          if (row_ph == '0) begin
            tag_row <= tag_row + CW'(1);
          end
        end
      end else begin
        col <= col + CW'(1);
        if (col_in) begin
          col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + CW'(1);
          if (col_ph == '0) begin
            tag_col <= tag_col + CW'(1);
          end
        end
      end
    end
  end

  // A new qualify wins over consumption, which gives back-to-back windows at one per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (qualify) begin
      win_valid <= 1'b1;
      out_row   <= tag_row;
      out_col   <= tag_col;
    end else if (dn_ready) begin
      win_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= drain_exit;
    end
  end

`ifdef DWC_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (win_valid && !dn_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_depthwise_win_sched.sv
// Directed bench for depthwise_win_sched: stride 1 and 2 frames, back-pressure, input gaps,
// ignored start, and mid-frame reset, each checked against a raster model of legal windows.
module tb_depthwise_win_sched;

  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sel;
  logic st_drv, pv_drv, dr_drv;

  logic start, pix_valid, dn_ready;
  logic pix_ready, shift_en, win_valid, busy, frame_done;
  logic [CW-1:0] out_row, out_col;

  logic start2, pix_valid2;
  logic pix_ready2, shift_en2, win_valid2, busy2, frame_done2;
  logic [CW-1:0] out_row2, out_col2;

`ifdef DWC_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt2;
`endif

  assign start      = st_drv & ~sel;
  assign pix_valid  = pv_drv & ~sel;
  assign start2     = st_drv & sel;
  assign pix_valid2 = pv_drv & sel;
  assign dn_ready   = dr_drv;

  depthwise_win_sched #(.IMG_W(12), .IMG_H(12), .K(5), .STRIDE(1), .CW(CW)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .shift_en   (shift_en),
    .win_valid  (win_valid),
    .dn_ready   (dn_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef DWC_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  depthwise_win_sched #(.IMG_W(12), .IMG_H(12), .K(5), .STRIDE(2), .CW(CW)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start2),
    .pix_valid  (pix_valid2),
    .pix_ready  (pix_ready2),
    .shift_en   (shift_en2),
    .win_valid  (win_valid2),
    .dn_ready   (dn_ready),
    .out_row    (out_row2),
    .out_col    (out_col2),
    .busy       (busy2),
    .frame_done (frame_done2)
`ifdef DWC_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt2)
`endif
  );

  // Observed instance, selected per frame
  logic m_wv, m_pr, m_se, m_fd;
  logic [CW-1:0] m_row, m_col;
  assign m_wv  = sel ? win_valid2  : win_valid;
  assign m_pr  = sel ? pix_ready2  : pix_ready;
  assign m_se  = sel ? shift_en2   : shift_en;
  assign m_fd  = sel ? frame_done2 : frame_done;
  assign m_row = sel ? out_row2    : out_row;
  assign m_col = sel ? out_col2    : out_col;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef logic [2*CW-1:0] tag_t;
  tag_t win_q[$];
  tag_t exp_q[$];

  bit mon_en = 1'b0;
  int cyc, n_acc, n_fd, n_stall;
  int acc52_cyc, first_win_cyc, last_acc_cyc, fd_cyc;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (m_wv && dr_drv) win_q.push_back({m_row, m_col});
      if (m_wv && first_win_cyc < 0) first_win_cyc = cyc;
      if (m_se) begin
        if (n_acc == 52) acc52_cyc = cyc;
        n_acc++;
        last_acc_cyc = cyc;
      end
      if (m_fd) begin
        n_fd++;
        fd_cyc = cyc;
      end
      if (m_wv && !dr_drv) begin
        n_stall++;
        check("stall_pix_ready", {31'd0, m_pr}, 32'd0);
        check("stall_tag_hold", {m_row, m_col}, {5'd2, 5'd5});
      end
    end
  end

  task automatic build_exp(input int s);
    exp_q.delete();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++)
        if (r >= 4 && c >= 4 && (r - 4) % s == 0 && (c - 4) % s == 0)
          exp_q.push_back({CW'((r - 4) / s), CW'((c - 4) / s)});
  endtask

  task automatic check_frame(input string name, input int s);
    build_exp(s);
    check({name, "_nwin"}, win_q.size(), exp_q.size());
    for (int i = 0; i < win_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_tag%0d", name, i), win_q[i], exp_q[i]);
    check({name, "_nacc"}, n_acc, 144);
    check({name, "_nfd"}, n_fd, 1);
    check({name, "_fd_lat"}, fd_cyc - last_acc_cyc, 2);
  endtask

  task automatic run_frame(input bit s2, input bit gaps, input bit stall, input bit mid_start,
                           input int rst_at);
    int  stall_left;
    int  post;
    bit  pulsed;
    bit  fin;
    stall_left = stall ? 3 : 0;
    post   = 0;
    pulsed = 1'b0;
    fin    = 1'b0;
    @(posedge clk); #1;
    sel           = s2;
    cyc           = 0;
    n_acc         = 0;
    n_fd          = 0;
    n_stall       = 0;
    acc52_cyc     = -1;
    first_win_cyc = -1;
    last_acc_cyc  = -1;
    fd_cyc        = -1;
    win_q.delete();
    mon_en = 1'b1;
    st_drv = 1'b1;
    pv_drv = 1'b0;
    dr_drv = 1'b1;
    @(posedge clk); #1;
    st_drv = 1'b0;
    for (int i = 0; i < 1000 && !fin; i++) begin
      pv_drv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall_left > 0 && m_wv && m_row == 5'd2 && m_col == 5'd5) begin
        dr_drv = 1'b0;
        stall_left--;
      end else begin
        dr_drv = 1'b1;
      end
      if (mid_start && !pulsed && n_acc >= 30) begin
        st_drv = 1'b1;
        pulsed = 1'b1;
      end else begin
        st_drv = 1'b0;
      end
      if (rst_at > 0 && n_acc == rst_at) begin
        // Pixel (4,11) was just accepted, so window (0,7) is pending when reset hits.
        check("rst_pre_wv", {31'd0, win_valid}, 32'd1);
        check("rst_pre_tag", {out_row, out_col}, {5'd0, 5'd7});
        #2 rst_n = 1'b0;
        #1;
        check("rst_wv", {31'd0, win_valid}, 32'd0);
        check("rst_tag", {out_row, out_col}, 32'd0);
        check("rst_ready", {31'd0, pix_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        fin = 1'b1;
      end else begin
        if (n_fd > 0) post++;
        if (post >= 3) fin = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    pv_drv = 1'b0;
    dr_drv = 1'b1;
    st_drv = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    sel    = 1'b0;
    st_drv = 1'b0;
    pv_drv = 1'b0;
    dr_drv = 1'b1;
    #12;
    check("reset_wv", {31'd0, win_valid}, 32'd0);
    check("reset_ready", {31'd0, pix_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_fd", {31'd0, frame_done}, 32'd0);
    check("reset_tag", {out_row, out_col}, 32'd0);
    check("reset_wv2", {31'd0, win_valid2}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_frame("s1", 1);
    check("s1_first_lat", first_win_cyc - acc52_cyc, 1);
    check("s1_last_tag", (win_q.size() > 0) ? win_q[win_q.size()-1] : '1, {5'd7, 5'd7});
    check("s1_idle_busy", {31'd0, busy}, 32'd0);

    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check_frame("s2", 2);
    check("s2_last_tag", (win_q.size() > 0) ? win_q[win_q.size()-1] : '1, {5'd3, 5'd3});

    run_frame(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_frame("stall", 1);
    check("stall_clks", n_stall, 3);
`ifdef DWC_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 3);
`endif

    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check_frame("gaps", 1);

    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 0);
    check_frame("mid_start", 1);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_frame("restart", 1);

    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 60);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_fd", n_fd, 0);
    check("rst_idle_busy", {31'd0, busy}, 32'd0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check_frame("post_rst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
